// File: rtl/yoda_pkg.sv
// yoda_pkg: definitions shared by the paralellizer and the serializer.
//   - state_t    : two-state handshake FSM encoding (S_WAIT, S_SEND)
//   - nib_of     : number of 4-bit nibbles in a word of the given width
//   - idx_width  : register width able to hold indices 0..count-1 (min 1)
package yoda_pkg;

  typedef enum logic {
    S_WAIT = 1'b0,
    S_SEND = 1'b1
  } state_t;

  localparam int NIBBLE_BITS = 4;

  function automatic int nib_of(input int width);
    return width / NIBBLE_BITS;
  endfunction

  function automatic int idx_width(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

endpackage

// File: rtl/serializer_nibble_shifter.sv
// nibble_shifter: holds one ciphertext word and walks it out MS nibble first.
//   clk, reset  : clock and synchronous active-high reset
//   load        : capture load_data, restart the nibble count
//   load_data   : word to be streamed
//   shift       : current nibble consumed; shift left by one nibble
//   nibble      : nibble currently presented (top 4 bits of the word)
//   last        : the presented nibble is the final one of the word
//   shreg, nib_cnt : debug mirrors, present only with SERIALIZER_WATCHERS_EN
module nibble_shifter
  import yoda_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int NIB   = nib_of(WIDTH),
  localparam int CW    = idx_width(NIB)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift,
  output logic [3:0]       nibble,
  output logic             last
`ifdef SERIALIZER_WATCHERS_EN
  ,
  output logic [WIDTH-1:0] shreg_out,
  output logic [CW-1:0]    nib_cnt_out
`endif
);

  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    nib_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg   <= '0;
      nib_cnt <= '0;
    end else if (load) begin
      shreg   <= load_data;
      nib_cnt <= '0;
    end else if (shift) begin
      // Zero-fill so a fully drained word leaves the output at 0.
      shreg   <= {shreg[WIDTH-5:0], 4'h0};
      nib_cnt <= nib_cnt + CW'(1);
    end
  end

  assign nibble = shreg[WIDTH-1 -: 4];
  assign last   = (nib_cnt == CW'(NIB - 1));

`ifdef SERIALIZER_WATCHERS_EN
  assign shreg_out   = shreg;
  assign nib_cnt_out = nib_cnt;
`endif

endmodule

// File: rtl/serializer.sv
// serializer: collects ciphertext words from NUM_ENCRYPTERS encrypters in
// strict round-robin order and streams each word over the QSPI nibble port.
//   clk, reset              : clock and synchronous active-high reset
//   encrypters_result[i]    : ciphertext of encrypter i
//   encrypters_result_valid : bit i high while result i is waiting
//   encrypters_result_ack   : one-cycle pulse, result i captured
//   qspi_data, qspi_sending : presented nibble and its qualifier
//   qspi_ready              : host consumes the nibble when high with sending
//   flush                   : restart round-robin at encrypter 0
// Optional debug build: define SERIALIZER_WATCHERS_EN to add state_out,
// encrypter_index_out, nibble_index_out and shreg_out mirror ports.
module serializer
  import yoda_pkg::*;
#(
  parameter  int ENCRYPTER_WIDTH = 32,
  parameter  int NUM_ENCRYPTERS  = 4,
  localparam int NIB             = nib_of(ENCRYPTER_WIDTH),
  localparam int IW              = idx_width(NUM_ENCRYPTERS),
  localparam int CW              = idx_width(NIB)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [ENCRYPTER_WIDTH-1:0] encrypters_result [NUM_ENCRYPTERS],
  input  logic [NUM_ENCRYPTERS-1:0]  encrypters_result_valid,
  output logic [NUM_ENCRYPTERS-1:0]  encrypters_result_ack,
  output logic [3:0]                 qspi_data,
  output logic                       qspi_sending,
  input  logic                       qspi_ready,
  input  logic                       flush
`ifdef SERIALIZER_WATCHERS_EN
  ,
  output logic                       state_out,
  output logic [IW-1:0]              encrypter_index_out,
  output logic [CW-1:0]              nibble_index_out,
  output logic [ENCRYPTER_WIDTH-1:0] shreg_out
`endif
);

  state_t                     state, state_next;
  logic [IW-1:0]              idx, idx_next;
  logic [NUM_ENCRYPTERS-1:0]  ack_next;
  logic                       load, shift, last;

  always_ff @(posedge clk) begin
    if (reset) begin
      state                 <= S_WAIT;
      idx                   <= '0;
      encrypters_result_ack <= '0;
    end else begin
      state                 <= state_next;
      idx                   <= idx_next;
      encrypters_result_ack <= ack_next;
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    ack_next   = '0;
    load       = 1'b0;
    shift      = 1'b0;
    case (state)
      S_WAIT: begin
        // flush outranks a pending capture on the same edge
        if (flush) begin
          idx_next = '0;
        end else if (encrypters_result_valid[idx]) begin
          load          = 1'b1;
          ack_next[idx] = 1'b1;
          state_next    = S_SEND;
        end
      end
      S_SEND: begin
        if (qspi_ready) begin
          shift = 1'b1;
          if (last) begin
            state_next = S_WAIT;
            idx_next   = (idx == IW'(NUM_ENCRYPTERS - 1)) ? '0 : idx + IW'(1);
          end
        end
      end
      default: state_next = S_WAIT;
    endcase
  end

  nibble_shifter #(
    .WIDTH(ENCRYPTER_WIDTH)
  ) u_shifter (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .load_data  (encrypters_result[idx]),
    .shift      (shift),
    .nibble     (qspi_data),
    .last       (last)
`ifdef SERIALIZER_WATCHERS_EN
    ,
    .shreg_out  (shreg_out),
    .nib_cnt_out(nibble_index_out)
`endif
  );

  // Both outputs come straight from registers (state and the shift register).
  assign qspi_sending = (state == S_SEND);

`ifdef SERIALIZER_WATCHERS_EN
  assign state_out           = state;
  assign encrypter_index_out = idx;
`endif

endmodule

// File: tb/tb_serializer.sv
module tb_serializer;
  localparam int W   = 32;
  localparam int N   = 4;
  localparam int NIB = W / 4;

  logic          clk = 1'b0;
  logic          reset, qspi_ready, flush, qspi_sending;
  logic [W-1:0]  result [N];
  logic [N-1:0]  valid, ack;
  logic [3:0]    qspi_data;
`ifdef SERIALIZER_WATCHERS_EN
  logic          state_w;
  logic [1:0]    enc_idx_w;
  logic [2:0]    nib_idx_w;
  logic [W-1:0]  shreg_w;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Encrypter feed model: word j of the stream belongs to encrypter j % N.
  bit            auto_feed = 1'b0;
  logic [W-1:0]  stream [64];
  int            total = 0;
  int            nxt [N];
  logic [W-1:0]  got [$];
  logic [N-1:0]  ack_seq [$];

  always #5 clk = ~clk;

  serializer #(
    .ENCRYPTER_WIDTH(W),
    .NUM_ENCRYPTERS (N)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .encrypters_result      (result),
    .encrypters_result_valid(valid),
    .encrypters_result_ack  (ack),
    .qspi_data              (qspi_data),
    .qspi_sending           (qspi_sending),
    .qspi_ready             (qspi_ready),
    .flush                  (flush)
`ifdef SERIALIZER_WATCHERS_EN
    ,
    .state_out              (state_w),
    .encrypter_index_out    (enc_idx_w),
    .nibble_index_out       (nib_idx_w),
    .shreg_out              (shreg_w)
`endif
  );

  // One clock; observe 1 time unit after the edge. Encrypters drop valid once
  // they see their ack, and the auto feed presents each encrypter's next word.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (ack[i]) valid[i] = 1'b0;
    if (auto_feed)
      for (int i = 0; i < N; i++)
        if (!valid[i] && nxt[i] < total) begin
          result[i] = stream[nxt[i]];
          valid[i]  = 1'b1;
          nxt[i]   += N;
        end
  endtask

  // Host side: consume nibbles with the given ready probability and assemble
  // words; records every ack pulse seen. Collection only, no checking.
  task automatic collect(input int nwords, input int ready_pct, input int budget);
    logic [W-1:0] cur = '0;
    int           cnt = 0;
    got.delete();
    ack_seq.delete();
    for (int c = 0; c < budget && got.size() < nwords; c++) begin
      qspi_ready = ($urandom_range(99) < ready_pct);
      if (ack != '0) ack_seq.push_back(ack);
      if (qspi_sending && qspi_ready) begin
        cur = {cur[W-5:0], qspi_data};
        cnt++;
        if (cnt == NIB) begin
          got.push_back(cur);
          $display("word %0d out: %h", got.size() - 1, cur);
          cnt = 0;
        end
      end
      tick();
    end
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; qspi_ready = 1'b0; valid = '0;
    for (int i = 0; i < N; i++) result[i] = '0;
    tick();
    tick();
    n_cmp++; if (qspi_sending !== 1'b0) begin n_bad++; $display("FAIL reset_sending: got %b expected 0", qspi_sending); end
    n_cmp++; if (qspi_data !== 4'h0) begin n_bad++; $display("FAIL reset_data: got %h expected 0", qspi_data); end
    n_cmp++; if (ack !== '0) begin n_bad++; $display("FAIL reset_ack: got %b expected 0000", ack); end
    reset = 1'b0;
    tick();
    n_cmp++; if (qspi_sending !== 1'b0 || ack !== '0) begin n_bad++; $display("FAIL reset_idle: got sending=%b ack=%b expected 0/0000", qspi_sending, ack); end
    $display("reset: done");
  endtask

  task automatic test_single_word();
    logic [W-1:0] w = 32'h12345678;
    result[0] = w; valid = 4'b0001; qspi_ready = 1'b1;
    tick();
    n_cmp++; if (ack !== 4'b0001) begin n_bad++; $display("FAIL single_ack: got %b expected 0001", ack); end
    for (int k = 0; k < NIB; k++) begin
      if (k > 0) tick();
      n_cmp++;
      if (qspi_sending !== 1'b1 || qspi_data !== w[W-1-4*k -: 4]) begin
        n_bad++; $display("FAIL single_nib%0d: got sending=%b data=%h expected 1/%h", k, qspi_sending, qspi_data, w[W-1-4*k -: 4]);
      end
      if (k == 1) begin
        n_cmp++; if (ack !== '0) begin n_bad++; $display("FAIL single_ack_pulse: got %b expected 0000", ack); end
      end
    end
    tick();
    n_cmp++; if (qspi_sending !== 1'b0) begin n_bad++; $display("FAIL single_idle: got %b expected 0", qspi_sending); end
    tick();
    n_cmp++; if (qspi_sending !== 1'b0) begin n_bad++; $display("FAIL single_no_idx1: got %b expected 0", qspi_sending); end
    $display("single word %h: done", w);
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] one = 1;
    logic [3:0]   en;
    do_flush();
    for (int i = 0; i < N; i++) result[i] = {8{4'(10 + i)}};
    valid = '1; qspi_ready = 1'b1;
    for (int w = 0; w < N; w++) begin
      en = 4'(10 + w);
      tick();
      n_cmp++; if (ack !== (one << w)) begin n_bad++; $display("FAIL b2b_ack%0d: got %b expected %b", w, ack, one << w); end
      for (int k = 0; k < NIB; k++) begin
        n_cmp++;
        if (qspi_sending !== 1'b1 || qspi_data !== en) begin
          n_bad++; $display("FAIL b2b_w%0d_nib%0d: got sending=%b data=%h expected 1/%h", w, k, qspi_sending, qspi_data, en);
        end
        tick();
      end
      n_cmp++; if (qspi_sending !== 1'b0) begin n_bad++; $display("FAIL b2b_gap%0d: got %b expected 0", w, qspi_sending); end
      $display("back-to-back word %0d (%h): done", w, result[w]);
    end
  endtask

  task automatic test_wrong_index();
    logic [W-1:0] r0 = $urandom;
    do_flush();
    result[2] = $urandom; valid = 4'b0100; qspi_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      n_cmp++;
      if (qspi_sending !== 1'b0 || ack !== '0) begin
        n_bad++; $display("FAIL wrongidx_c%0d: got sending=%b ack=%b expected 0/0000", c, qspi_sending, ack);
      end
    end
    result[0] = r0; valid[0] = 1'b1;
    tick();
    n_cmp++; if (ack !== 4'b0001) begin n_bad++; $display("FAIL wrongidx_ack: got %b expected 0001", ack); end
    collect(1, 100, 50);
    n_cmp++; if (got.size() != 1 || got[0] !== r0) begin n_bad++; $display("FAIL wrongidx_word: got %0d words first=%h expected %h", got.size(), (got.size() > 0) ? got[0] : '0, r0); end
    valid = '0;
    $display("wrong index then idx0 word %h: done", r0);
  endtask

  task automatic test_ready_toggle();
    logic [W-1:0] w = 32'h9876ABCD;
    bit           pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int           pos = 0;
    do_flush();
    qspi_ready = 1'b0; result[0] = w; valid = 4'b0001;
    tick();
    for (int c = 0; c < 64 && pos < NIB; c++) begin
      qspi_ready = pat[c % 4];
      n_cmp++;
      if (qspi_sending !== 1'b1 || qspi_data !== w[W-1-4*pos -: 4]) begin
        n_bad++; $display("FAIL toggle_c%0d: got sending=%b data=%h expected 1/%h", c, qspi_sending, qspi_data, w[W-1-4*pos -: 4]);
      end
      if (qspi_ready) pos++;
      tick();
    end
    n_cmp++; if (pos != NIB || qspi_sending !== 1'b0) begin n_bad++; $display("FAIL toggle_end: got pos=%0d sending=%b expected %0d/0", pos, qspi_sending, NIB); end
    $display("ready toggle word %h: done", w);
  endtask

  task automatic test_flush();
    logic [W-1:0] r0 = $urandom;
    logic [W-1:0] r1 = $urandom;
    logic [W-1:0] r2 = $urandom;
    do_flush();
    result[0] = r0; result[1] = r1; valid = 4'b0011; qspi_ready = 1'b1;
    collect(2, 100, 100);
    n_cmp++; if (got.size() != 2 || got[0] !== r0 || got[1] !== r1) begin n_bad++; $display("FAIL flush_pre: got %0d words expected %h %h", got.size(), r0, r1); end
    result[2] = $urandom; valid[2] = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0;
    n_cmp++; if (ack !== '0 || qspi_sending !== 1'b0) begin n_bad++; $display("FAIL flush_nocap: got ack=%b sending=%b expected 0000/0", ack, qspi_sending); end
    tick();
    n_cmp++; if (ack !== '0 || qspi_sending !== 1'b0) begin n_bad++; $display("FAIL flush_idx0: got ack=%b sending=%b expected 0000/0", ack, qspi_sending); end
    result[0] = r2; valid[0] = 1'b1;
    tick();
    n_cmp++; if (ack !== 4'b0001) begin n_bad++; $display("FAIL flush_ack0: got %b expected 0001", ack); end
    collect(1, 100, 50);
    n_cmp++; if (got.size() != 1 || got[0] !== r2) begin n_bad++; $display("FAIL flush_word: got %0d words first=%h expected %h", got.size(), (got.size() > 0) ? got[0] : '0, r2); end
    valid = '0;
    $display("flush with valid[2]: done");
  endtask

  task automatic test_reset_midword();
    logic [W-1:0] r0 = $urandom;
    logic [W-1:0] r1 = $urandom;
    logic [W-1:0] r2 = $urandom;
    logic [W-1:0] r3 = $urandom;
    do_flush();
    result[0] = r0; result[1] = r1; valid = 4'b0011; qspi_ready = 1'b1;
    tick();
    collect(1, 100, 50);
    tick();
    n_cmp++; if (ack !== 4'b0010) begin n_bad++; $display("FAIL rstmid_ack1: got %b expected 0010", ack); end
    qspi_ready = 1'b1;
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    n_cmp++;
    if (qspi_sending !== 1'b0 || qspi_data !== 4'h0 || ack !== '0) begin
      n_bad++; $display("FAIL rstmid_outs: got sending=%b data=%h ack=%b expected 0/0/0000", qspi_sending, qspi_data, ack);
    end
    reset = 1'b0;
    result[0] = r2; result[1] = r3; valid = 4'b0011;
    tick();
    n_cmp++; if (ack !== 4'b0001 || qspi_data !== r2[W-1 -: 4]) begin n_bad++; $display("FAIL rstmid_restart: got ack=%b data=%h expected 0001/%h", ack, qspi_data, r2[W-1 -: 4]); end
    collect(1, 100, 50);
    n_cmp++; if (got.size() != 1 || got[0] !== r2) begin n_bad++; $display("FAIL rstmid_word: got %0d words first=%h expected %h", got.size(), (got.size() > 0) ? got[0] : '0, r2); end
    valid = '0;
    $display("reset mid-word: done");
  endtask

  task automatic test_random();
    logic [N-1:0] one = 1;
    reset = 1'b1;
    tick();
    reset = 1'b0; valid = '0; qspi_ready = 1'b0;
    total = 24;
    for (int j = 0; j < total; j++) stream[j] = $urandom;
    for (int i = 0; i < N; i++) nxt[i] = i;
    auto_feed = 1'b1;
    collect(total, 60, 3000);
    auto_feed = 1'b0;
    valid = '0;
    n_cmp++; if (got.size() != total) begin n_bad++; $display("FAIL rand_count: got %0d words expected %0d", got.size(), total); end
    for (int j = 0; j < got.size() && j < total; j++) begin
      n_cmp++; if (got[j] !== stream[j]) begin n_bad++; $display("FAIL rand_word%0d: got %h expected %h", j, got[j], stream[j]); end
    end
    n_cmp++; if (ack_seq.size() != total) begin n_bad++; $display("FAIL rand_ackcount: got %0d expected %0d", ack_seq.size(), total); end
    for (int j = 0; j < ack_seq.size() && j < total; j++) begin
      n_cmp++; if (ack_seq[j] !== (one << (j % N))) begin n_bad++; $display("FAIL rand_ack%0d: got %b expected %b", j, ack_seq[j], one << (j % N)); end
    end
    $display("random stream of %0d words: done", total);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; qspi_ready = 1'b0; valid = '0;
    for (int i = 0; i < N; i++) begin result[i] = '0; nxt[i] = 0; end
    test_reset();
    test_single_word();
    test_back_to_back();
    test_wrong_index();
    test_ready_toggle();
    test_flush();
    test_reset_midword();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serializer.md
# serializer

Output-side counterpart of the paralellizer: collects finished ciphertext words from the `NUM_ENCRYPTERS` encrypters in strict round-robin order (index 0, 1, …, N-1, 0, …) and streams each word out over the QSPI nibble interface. Results leave in the same order the paralellizer dispatched plaintext. Sits between the encrypter array and the QSPI output pins.

## Interface

Parameters:
- `ENCRYPTER_WIDTH`, 32: bits per encrypter result. Multiple of 4, ≥ 8.
- `NUM_ENCRYPTERS`, 4: number of encrypters. ≥ 2.

Ports (NIB = `ENCRYPTER_WIDTH`/4):
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `encrypters_result`  in  `ENCRYPTER_WIDTH` × `NUM_ENCRYPTERS` (unpacked array)  ciphertext per encrypter.
- `encrypters_result_valid`  in  `NUM_ENCRYPTERS`  bit i high: result i is ready; held until acked.
- `encrypters_result_ack`  out  `NUM_ENCRYPTERS`  one-cycle pulse; result i captured.
- `qspi_data`  out  4  current nibble.
- `qspi_sending`  out  1  high while `qspi_data` carries a valid nibble.
- `qspi_ready`  in  1  host consumes the nibble on an edge where this and `qspi_sending` are both high.
- `flush`  in  1  restart round-robin at encrypter 0 (end of a partial group).

## Operation

- States: `S_WAIT`, `S_SEND`. Registers: `idx` ($clog2(N) bits), `shreg` (`ENCRYPTER_WIDTH`), `nib_cnt` ($clog2(NIB) bits).
- `S_WAIT`: `qspi_sending`=0. On an edge with `flush`=1: `idx`←0, stay. Else if `encrypters_result_valid[idx]`=1: `shreg`←`encrypters_result[idx]`, `nib_cnt`←0, `encrypters_result_ack[idx]`←1 for exactly the next cycle, go to `S_SEND`. Valid bits of other indices are ignored.
- `S_SEND`: `qspi_sending`=1, `qspi_data`=`shreg[W-1:W-4]` (MS nibble first). On edge with `qspi_ready`=1: `shreg` shifts left 4, `nib_cnt`+1. When the nibble with `nib_cnt`=NIB-1 is consumed: `idx`←`idx`+1 (wraps N-1→0), go to `S_WAIT`. `qspi_ready`=0: hold nibble and count indefinitely. `flush` ignored.
- Valid still high during the ack cycle is ignored (state is `S_SEND`); encrypter drops valid after seeing ack.
- Reset (any state, incl. mid-word): `S_WAIT`, `idx`=0, `shreg`=0, `nib_cnt`=0, partial word discarded, no ack.

## Timing

- Reset values: `qspi_data`=0, `qspi_sending`=0, `encrypters_result_ack`=0.
- Outputs are registered. Valid sampled high at edge N → after edge N: ack high one cycle, `qspi_sending`=1, first nibble on `qspi_data`.
- With `qspi_ready` held high: word occupies NIB cycles of `qspi_sending`, then exactly one `S_WAIT` cycle (`qspi_sending`=0) before the next word; throughput NIB+1 cycles/word.
- `flush` and valid[idx] on the same `S_WAIT` edge: flush wins, no capture, next check is of index 0.

## Configuration

- `SERIALIZER_WATCHERS_EN` defined: extra outputs `state_out` (1), `encrypter_index_out` ($clog2(N)), `nibble_index_out` ($clog2(NIB)), `shreg_out` (`ENCRYPTER_WIDTH`) mirror the internal registers for waveform debug.
- Undefined: those ports and their logic are absent; functional behaviour identical.

## Structure

- Shared package `yoda_pkg`: state enum typedef (`S_WAIT`, `S_SEND`), NIB derivation, index width helpers; used by paralellizer and serializer alike.
- One sub-module: `nibble_shifter` (load, shift-on-ready, `shreg`/`nib_cnt`, `last` flag); top holds FSM, `idx`, ack generation.

## Test plan

- Reset then valid[0]=1 with result0=0x12345678, `qspi_ready`=1 → ack[0] one cycle; nibbles 1,2,…,8 on 8 consecutive cycles; `qspi_sending` low next cycle.
- All four valid at once, results 0xA…A,0xB…B,0xC…C,0xD…D → words emitted in order A,B,C,D, each 8 nibbles, one idle cycle between; acks 0→3 in order.
- valid[2]=1 only, `idx`=0 → no ack, `qspi_sending` stays 0 until valid[0] arrives.
- `qspi_ready` toggled 1,0,0,1… during word 0x9876ABCD → each nibble held while ready=0; sequence 9,8,7,6,A,B,C,D unaltered.
- After two words (`idx`=2), `flush`=1 with valid[2]=1 same cycle → no ack[2]; next word taken from encrypter 0.
- `reset` pulsed after third nibble of a word → next edge `qspi_sending`=0, `qspi_data`=0; following word starts at encrypter 0 with its MS nibble.
